// File: rtl/srt_prenorm_if.sv
// Operand/result handshake bundle between the upstream source, srt_prenorm and the SRT divider core.
// master = upstream/core side, slave = srt_prenorm side.
interface srt_prenorm_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] n_in;
    logic [WIDTH-1:0] d_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] n_out;
    logic [WIDTH-1:0] d_out;
    logic [SHW-1:0]   shamt;
    logic             div_by_zero;

    modport master (
        output in_valid, n_in, d_in, out_ready,
        input  in_ready, out_valid, n_out, d_out, shamt, div_by_zero
    );

    modport slave (
        input  in_valid, n_in, d_in, out_ready,
        output in_ready, out_valid, n_out, d_out, shamt, div_by_zero
    );
endinterface

// File: rtl/srt_prenorm.sv
// Divisor pre-normalisation for the radix-4 SRT core: shifts the divisor left until its MSB is set.
// Optional macro SRT_PRENORM_FAST_LZC_EN: single-cycle shift via a leading-zero encoder.
module srt_prenorm #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         resetn,
    srt_prenorm_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic             dbz_q, dbz_d;

`ifdef SRT_PRENORM_FAST_LZC_EN
    logic [SHW-1:0] lzc;
    logic [SHW-1:0] lzc_q, lzc_d;
    logic           lzcFound;

    // A zero divisor yields a count of 0, so it passes through unshifted.
    always_comb begin
        lzc      = '0;
        lzcFound = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!lzcFound && bus.d_in[i]) begin
                lzc      = SHW'(WIDTH - 1 - i);
                lzcFound = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            shamt_q <= '0;
            dbz_q   <= 1'b0;
`ifdef SRT_PRENORM_FAST_LZC_EN
            lzc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            shamt_q <= shamt_d;
            dbz_q   <= dbz_d;
`ifdef SRT_PRENORM_FAST_LZC_EN
            lzc_q   <= lzc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        shamt_d = shamt_q;
        dbz_d   = dbz_q;
`ifdef SRT_PRENORM_FAST_LZC_EN
        lzc_d   = lzc_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    n_d     = bus.n_in;
                    d_d     = bus.d_in;
                    shamt_d = '0;
                    dbz_d   = (bus.d_in == '0);
`ifdef SRT_PRENORM_FAST_LZC_EN
                    lzc_d   = lzc;
`endif
                    state_d = NORM;
                end
            end
            NORM: begin
`ifdef SRT_PRENORM_FAST_LZC_EN
                d_d     = d_q << lzc_q;
                shamt_d = lzc_q;
                state_d = DONE;
`else
                // The MSB check bounds shamt at WIDTH-1, so it cannot wrap.
                if (!d_q[WIDTH-1] && (d_q != '0)) begin
                    d_d     = d_q << 1;
                    shamt_d = shamt_q + SHW'(1);
                end else begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.n_out       = n_q;
    assign bus.d_out       = d_q;
    assign bus.shamt       = shamt_q;
    assign bus.div_by_zero = dbz_q;

endmodule
